frame_scheduler: RTL and testbench
==================================

Name: frame_scheduler

Overview:
- Sequences the Tetris board RAM around the HDMI timing generator's outputs (VDE, CD={vsync,hsync}).
- The renderer owns the RAM during scan-out. Game logic gets a bounded write window each vertical blank.
- Produces a gravity tick every N frames.
- Sits between the timing generator, the renderer, the game-logic FSM and the single-port board RAM.

Parameters:
- ADDR_W, 8, board RAM address width
- DATA_W, 4, board RAM data width (cell colour code)
- UPD_CYCLES, 256, maximum game-logic accesses per vertical blank
- DIV_W, 5, width of the speed_div input

Ports:
- pixclk  in  1  pixel clock; single clock domain
- reset  in  1  asynchronous, active-low reset
- vde  in  1  video data enable from the timing generator
- cd  in  2  {vsync, hsync} from the timing generator; sync pulses are active-low
- speed_div  in  DIV_W  frames per gravity tick; 0 is treated as 1
- pause  in  1  freezes the tick counter
- rd_req  in  1  renderer read request
- rd_addr  in  ADDR_W  renderer address
- gl_req  in  1  game-logic access request
- gl_we  in  1  game-logic write enable
- gl_addr  in  ADDR_W  game-logic address
- gl_wdata  in  DATA_W  game-logic write data
- gl_gnt  out  1  combinational grant: gl access accepted this cycle
- rd_valid  out  1  mem_rdata valid for the renderer
- mem_addr  out  ADDR_W  registered RAM address
- mem_we  out  1  registered RAM write enable
- mem_wdata  out  DATA_W  registered RAM write data
- frame_start  out  1  1-cycle pulse per frame
- tick  out  1  1-cycle gravity pulse
- upd_window  out  1  high while game logic owns the RAM

Behaviour:
- Reset (reset=0, async): state=S_SCAN, vs_q=1, frame_cnt=0, win_cnt=0. All outputs 0; mem_addr and mem_wdata are 0.
- Frame edge: vs_q registers cd[1]. vs_fall = vs_q & ~cd[1]. frame_start is registered, so it is high the cycle after vs_fall.
- Tick:
  - On vs_fall with pause=0: if frame_cnt >= max(speed_div,1)-1, then tick<=1 and frame_cnt<=0; else frame_cnt++.
  - With pause=1, frame_cnt holds and tick stays 0; frame_start still pulses.
  - Lowering speed_div below frame_cnt fires on the next vs_fall.
- FSM states:
  - S_SCAN: renderer owns the RAM. On vs_fall go to S_UPDATE and load win_cnt=UPD_CYCLES.
  - S_UPDATE: upd_window=1. On each gl_gnt, win_cnt--. Go to S_LOCK when win_cnt reaches 0 after a grant, or when vde=1 (vde takes precedence).
  - S_LOCK: upd_window=0, gl_gnt=0. Wait for vs_q=1 and vde=1, then go to S_SCAN. This prevents a second window opening in the same blank.
  - A vs_fall seen in S_UPDATE or S_LOCK is ignored for windowing; the tick logic still counts it.
- Arbitration:
  - gl_gnt = gl_req & (state==S_UPDATE) & ~vde & (win_cnt!=0).
  - When gl_gnt=1 the gl request wins: mem_addr<=gl_addr, mem_we<=gl_we, mem_wdata<=gl_wdata.
  - Otherwise, if rd_req=1: mem_addr<=rd_addr, mem_we<=0. Renderer requests outside S_UPDATE are always served.
  - Otherwise mem_we<=0 and mem_addr holds.
- Latency:
  - A gl or rd access accepted in cycle N appears on mem_* at N+1.
  - The RAM is synchronous, so read data arrives at N+2. rd_valid is asserted at N+2 for each served rd_req.
  - A rd_req starved by a gl grant gets no rd_valid; the renderer re-presents it.
- Window closing mid-burst: gl_gnt drops in the same cycle vde rises. The pending gl_req stays unserved until the next window. There is no partial write: mem_we is only ever set from a granted cycle.
- Reset mid-window: the async clear aborts the window. Any in-flight write registered before reset is dropped (mem_we cleared). The next window opens only on a fresh vs_fall.

Decomposition:
- Package tetris_video_pkg holds:
  - state encoding S_SCAN/S_UPDATE/S_LOCK
  - ADDR_W and DATA_W defaults
  - board geometry constants shared with the renderer
- Sub-module frame_tick_gen contains vs_q, vs_fall, frame_start, frame_cnt and tick. It is instantiated once.

Test Plan:
- Reset with cd=2'b11, vde=1, then release -> all outputs 0, state S_SCAN; no frame_start until cd[1] falls.
- speed_div=3, pause=0, 7 vsync falls -> frame_start pulses 7 times; tick pulses on falls 3 and 6 only, each 1 cycle after the fall.
- UPD_CYCLES=8; gl_req held with vde=0 from the vsync fall -> exactly 8 gl_gnt cycles, then upd_window=0 and state S_LOCK; mem_we high on 8 consecutive cycles starting 1 cycle after the first grant.
- gl_req and rd_req both high in S_UPDATE, gl_addr=0x10, rd_addr=0x20 -> mem_addr=0x10 next cycle, no rd_valid. Same requests in S_SCAN -> mem_addr=0x20, rd_valid 2 cycles later, gl_gnt=0.
- vde rises after 3 grants with UPD_CYCLES=8 -> gl_gnt=0 in that same cycle; no window reopens until the next vsync fall.
- reset asserted mid-window after 2 writes -> mem_we=0 immediately, state S_SCAN; pause=1 across 4 frames -> frame_start=4 pulses, tick=0, frame_cnt unchanged.

Source files
------------

// File: rtl/tetris_video_pkg.sv
// Shared types and constants for the Tetris video path: scheduler state
// encoding, default RAM widths and the board geometry the renderer walks.
package tetris_video_pkg;

    localparam int ADDR_W_DEFAULT = 8;
    localparam int DATA_W_DEFAULT = 4;

    localparam int BOARD_COLS  = 10;
    localparam int BOARD_ROWS  = 20;
    localparam int BOARD_CELLS = BOARD_COLS * BOARD_ROWS;

    typedef enum logic [1:0] {
        S_SCAN   = 2'd0,
        S_UPDATE = 2'd1,
        S_LOCK   = 2'd2
    } sched_state_t;

endpackage

// File: rtl/frame_tick_gen.sv
// Detects the falling edge of vsync, emits a registered frame_start pulse
// and a gravity tick every max(speed_div,1) unpaused frames.
module frame_tick_gen #(
    parameter int DIV_W = 5
) (
    input  logic             pixclk,
    input  logic             reset,
    input  logic             vsync,
    input  logic [DIV_W-1:0] speed_div,
    input  logic             pause,
    output logic             vs_q,
    output logic             vs_fall,
    output logic             frame_start,
    output logic             tick
);

    logic [DIV_W-1:0] frame_cnt;
    logic [DIV_W-1:0] last_cnt;

    assign vs_fall  = vs_q & ~vsync;
    // A divider of 0 behaves like 1, so the last count is 0 in both cases.
    assign last_cnt = (speed_div == '0) ? '0 : speed_div - DIV_W'(1);

    always_ff @(posedge pixclk or negedge reset) begin
        if (!reset) begin
            vs_q        <= 1'b1;
            frame_start <= 1'b0;
            tick        <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            vs_q        <= vsync;
            frame_start <= vs_fall;
            tick        <= 1'b0;
            // Using >= lets a lowered divider fire on the very next frame.
            if (vs_fall && !pause) begin
                if (frame_cnt >= last_cnt) begin
                    tick      <= 1'b1;
                    frame_cnt <= '0;
                end else begin
                    frame_cnt <= frame_cnt + DIV_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/frame_scheduler.sv
// Arbitrates the single-port board RAM between the renderer and game logic,
// opening one bounded game-logic window per vertical blank.
module frame_scheduler
    import tetris_video_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEFAULT,
    parameter int DATA_W     = DATA_W_DEFAULT,
    parameter int UPD_CYCLES = 256,
    parameter int DIV_W      = 5
) (
    input  logic              pixclk,
    input  logic              reset,
    input  logic              vde,
    input  logic [1:0]        cd,
    input  logic [DIV_W-1:0]  speed_div,
    input  logic              pause,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              gl_req,
    input  logic              gl_we,
    input  logic [ADDR_W-1:0] gl_addr,
    input  logic [DATA_W-1:0] gl_wdata,
    output logic              gl_gnt,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              frame_start,
    output logic              tick,
    output logic              upd_window
);

    localparam int WIN_W = $clog2(UPD_CYCLES + 1);

    sched_state_t     state;
    sched_state_t     state_nxt;
    logic [WIN_W-1:0] win_cnt;
    logic             vs_q;
    logic             vs_fall;
    logic             rd_served;
    logic             rd_pend;
    // hsync plays no part in scheduling; only vsync marks frames.
    logic             hsync_unused;

    assign hsync_unused = cd[0];

    frame_tick_gen #(
        .DIV_W (DIV_W)
    ) u_tick (
        .pixclk      (pixclk),
        .reset       (reset),
        .vsync       (cd[1]),
        .speed_div   (speed_div),
        .pause       (pause),
        .vs_q        (vs_q),
        .vs_fall     (vs_fall),
        .frame_start (frame_start),
        .tick        (tick)
    );

    assign gl_gnt     = gl_req & (state == S_UPDATE) & ~vde & (win_cnt != '0);
    assign rd_served  = rd_req & ~gl_gnt;
    assign upd_window = (state == S_UPDATE);

    always_ff @(posedge pixclk or negedge reset) begin
        if (!reset) begin
            state <= S_SCAN;
        end else begin
            state <= state_nxt;
        end
    end

    // S_LOCK holds until active video resumes so one blank never gets two windows.
    always_comb begin
        state_nxt = state;
        case (state)
            S_SCAN: begin
                if (vs_fall) state_nxt = S_UPDATE;
            end
            S_UPDATE: begin
                if (vde) begin
                    state_nxt = S_LOCK;
                end else if (gl_gnt && (win_cnt == WIN_W'(1))) begin
                    state_nxt = S_LOCK;
                end
            end
            S_LOCK: begin
                if (vs_q && vde) state_nxt = S_SCAN;
            end
            default: state_nxt = S_SCAN;
        endcase
    end

    always_ff @(posedge pixclk or negedge reset) begin
        if (!reset) begin
            win_cnt <= '0;
        end else if ((state == S_SCAN) && vs_fall) begin
            win_cnt <= WIN_W'(UPD_CYCLES);
        end else if (gl_gnt) begin
            win_cnt <= win_cnt - WIN_W'(1);
        end
    end

    // Granted game-logic access beats the renderer; a starved read gets no rd_valid.
    always_ff @(posedge pixclk or negedge reset) begin
        if (!reset) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            rd_pend   <= 1'b0;
            rd_valid  <= 1'b0;
        end else begin
            rd_pend  <= rd_served;
            rd_valid <= rd_pend;
            if (gl_gnt) begin
                mem_addr  <= gl_addr;
                mem_we    <= gl_we;
                mem_wdata <= gl_wdata;
            end else begin
                mem_we <= 1'b0;
                if (rd_req) mem_addr <= rd_addr;
            end
        end
    end

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler: a frame-level reference model is
// compared against the DUT every cycle, plus hand-computed pulse counts.
`timescale 1ns/1ps
module tb_frame_scheduler;

    localparam int ADDR_W     = 8;
    localparam int DATA_W     = 4;
    localparam int UPD_CYCLES = 8;
    localparam int DIV_W      = 5;

    logic              pixclk = 1'b0;
    logic              reset  = 1'b0;
    logic              vde    = 1'b1;
    logic [1:0]        cd     = 2'b11;
    logic [DIV_W-1:0]  speed_div = 5'd3;
    logic              pause  = 1'b0;
    logic              rd_req = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic              gl_req = 1'b0;
    logic              gl_we  = 1'b0;
    logic [ADDR_W-1:0] gl_addr = '0;
    logic [DATA_W-1:0] gl_wdata = '0;
    logic              gl_gnt;
    logic              rd_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic              frame_start;
    logic              tick;
    logic              upd_window;

    frame_scheduler #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .UPD_CYCLES (UPD_CYCLES),
        .DIV_W      (DIV_W)
    ) dut (
        .pixclk      (pixclk),
        .reset       (reset),
        .vde         (vde),
        .cd          (cd),
        .speed_div   (speed_div),
        .pause       (pause),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .gl_req      (gl_req),
        .gl_we       (gl_we),
        .gl_addr     (gl_addr),
        .gl_wdata    (gl_wdata),
        .gl_gnt      (gl_gnt),
        .rd_valid    (rd_valid),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .frame_start (frame_start),
        .tick        (tick),
        .upd_window  (upd_window)
    );

    always #5 pixclk = ~pixclk;

    int tests_run    = 0;
    int tests_failed = 0;
    bit cmp_en       = 1'b0;

    // Reference model: frames counted since the last tick, a grant budget per blank.
    bit                m_prev_vs = 1'b1;
    bit                m_in_window = 1'b0;
    bit                m_locked = 1'b0;
    int                m_grants_left = 0;
    int                m_frames = 0;
    logic              m_frame_start = 1'b0;
    logic              m_tick = 1'b0;
    logic              m_rd_pipe = 1'b0;
    logic              m_rd_valid = 1'b0;
    logic              m_mem_we = 1'b0;
    logic [ADDR_W-1:0] m_mem_addr = '0;
    logic [DATA_W-1:0] m_mem_wdata = '0;

    int fs_seen, tick_seen, gnt_seen, we_seen, we_run, we_max;
    logic [31:0] tick_mask;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic bit model_gnt();
        return gl_req && m_in_window && !vde && (m_grants_left > 0);
    endfunction

    task automatic model_step();
        bit fall;
        bit gnt;
        int div;
        if (!reset) begin
            m_prev_vs = 1'b1; m_in_window = 1'b0; m_locked = 1'b0;
            m_grants_left = 0; m_frames = 0;
            m_frame_start = 1'b0; m_tick = 1'b0; m_rd_pipe = 1'b0; m_rd_valid = 1'b0;
            m_mem_we = 1'b0; m_mem_addr = '0; m_mem_wdata = '0;
        end else begin
            fall = m_prev_vs && !cd[1];
            gnt  = model_gnt();
            div  = (speed_div == 0) ? 1 : int'(speed_div);
            m_rd_valid = m_rd_pipe;
            m_rd_pipe  = rd_req && !gnt;
            if (gnt) begin
                m_mem_addr = gl_addr; m_mem_we = gl_we; m_mem_wdata = gl_wdata;
            end else begin
                m_mem_we = 1'b0;
                if (rd_req) m_mem_addr = rd_addr;
            end
            if (m_in_window) begin
                if (vde) begin
                    m_in_window = 1'b0; m_locked = 1'b1;
                end else if (gnt) begin
                    m_grants_left--;
                    if (m_grants_left == 0) begin
                        m_in_window = 1'b0; m_locked = 1'b1;
                    end
                end
            end else if (m_locked) begin
                if (m_prev_vs && vde) m_locked = 1'b0;
            end else if (fall) begin
                m_in_window = 1'b1; m_grants_left = UPD_CYCLES;
            end
            m_frame_start = fall;
            m_tick = 1'b0;
            if (fall && !pause) begin
                m_frames++;
                if (m_frames >= div) begin
                    m_tick = 1'b1; m_frames = 0;
                end
            end
            m_prev_vs = cd[1];
        end
    endtask

    initial forever begin
        @(posedge pixclk or negedge reset);
        model_step();
    end

    initial forever begin
        @(negedge pixclk);
        if (reset && cmp_en) begin
            check_output("gl_gnt", gl_gnt, model_gnt());
            check_output("upd_window", upd_window, m_in_window);
            check_output("frame_start", frame_start, m_frame_start);
            check_output("tick", tick, m_tick);
            check_output("rd_valid", rd_valid, m_rd_valid);
            check_output("mem_we", mem_we, m_mem_we);
            check_output("mem_addr", mem_addr, m_mem_addr);
            check_output("mem_wdata", mem_wdata, m_mem_wdata);
        end
    end

    initial forever begin
        @(negedge pixclk);
        if (reset) begin
            if (frame_start) begin
                fs_seen++;
                if (tick && fs_seen >= 1 && fs_seen <= 32) tick_mask = tick_mask | (32'd1 << (fs_seen - 1));
            end
            if (tick) tick_seen++;
            if (gl_gnt) gnt_seen++;
            if (mem_we) begin
                we_seen++; we_run++;
                if (we_run > we_max) we_max = we_run;
            end else begin
                we_run = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) @(posedge pixclk);
        #1;
    endtask

    task automatic clear_counts();
        fs_seen = 0; tick_seen = 0; gnt_seen = 0;
        we_seen = 0; we_run = 0; we_max = 0; tick_mask = '0;
    endtask

    task automatic apply_stimulus(input bit g_req, input bit g_we, input logic [ADDR_W-1:0] g_addr,
                                  input logic [DATA_W-1:0] g_data, input bit r_req,
                                  input logic [ADDR_W-1:0] r_addr);
        gl_req = g_req; gl_we = g_we; gl_addr = g_addr; gl_wdata = g_data;
        rd_req = r_req; rd_addr = r_addr;
    endtask

    task automatic run_frame(input int vs_low, input int blank, input int active);
        cd = 2'b01; vde = 1'b0; step(vs_low);
        cd = 2'b11; step(blank);
        vde = 1'b1; step(active);
    endtask

    initial begin
        clear_counts();
        step(3);
        check_output("reset_gl_gnt", gl_gnt, 0);
        check_output("reset_upd_window", upd_window, 0);
        check_output("reset_mem_we", mem_we, 0);
        check_output("reset_mem_addr", mem_addr, 0);
        check_output("reset_mem_wdata", mem_wdata, 0);
        check_output("reset_rd_valid", rd_valid, 0);
        check_output("reset_frame_start", frame_start, 0);
        check_output("reset_tick", tick, 0);

        reset = 1'b1; cmp_en = 1'b1;
        step(6);
        check_output("no_frame_without_fall", fs_seen, 0);

        // Seven frames at speed_div=3: ticks on frames 3 and 6.
        clear_counts();
        repeat (7) run_frame(2, 4, 4);
        check_output("frames_7", fs_seen, 7);
        check_output("ticks_2", tick_seen, 2);
        check_output("tick_frames", tick_mask, 32'h24);

        // Budget exhaustion: exactly UPD_CYCLES grants per blank.
        clear_counts();
        apply_stimulus(1, 1, 8'h33, 4'h9, 0, 8'h00);
        cd = 2'b01; vde = 1'b0; step(2);
        cd = 2'b11; step(12);
        check_output("budget_grants", gnt_seen, 8);
        check_output("budget_writes", we_seen, 8);
        check_output("budget_write_run", we_max, 8);
        check_output("budget_window_closed", upd_window, 0);
        check_output("budget_no_gnt_locked", gl_gnt, 0);
        apply_stimulus(0, 0, 8'h00, 4'h0, 0, 8'h00);
        vde = 1'b1; step(4);

        // Arbitration inside and outside the window.
        apply_stimulus(0, 0, 8'h00, 4'h0, 0, 8'h00);
        cd = 2'b01; vde = 1'b0; step(1);
        cd = 2'b11;
        apply_stimulus(1, 1, 8'h10, 4'h5, 1, 8'h20);
        #1;
        check_output("arb_gnt_in_update", gl_gnt, 1);
        step(1);
        check_output("arb_gl_addr", mem_addr, 8'h10);
        check_output("arb_gl_we", mem_we, 1);
        apply_stimulus(0, 0, 8'h00, 4'h0, 0, 8'h00);
        step(1);
        check_output("arb_starved_no_valid", rd_valid, 0);
        vde = 1'b1; step(3);
        apply_stimulus(1, 1, 8'h10, 4'h5, 1, 8'h20);
        #1;
        check_output("arb_scan_no_gnt", gl_gnt, 0);
        step(1);
        check_output("arb_rd_addr", mem_addr, 8'h20);
        check_output("arb_rd_we", mem_we, 0);
        apply_stimulus(0, 0, 8'h00, 4'h0, 0, 8'h00);
        check_output("arb_rd_valid_n1", rd_valid, 0);
        step(1);
        check_output("arb_rd_valid_n2", rd_valid, 1);
        step(2);

        // vde rising mid-burst closes the window for the rest of the blank.
        clear_counts();
        apply_stimulus(1, 1, 8'h44, 4'h3, 0, 8'h00);
        cd = 2'b01; vde = 1'b0; step(1);
        cd = 2'b11; step(3);
        vde = 1'b1;
        #1;
        check_output("vde_cut_gnt", gl_gnt, 0);
        check_output("vde_cut_grants", gnt_seen, 3);
        step(3);
        vde = 1'b0; step(5);
        check_output("vde_no_reopen", gnt_seen, 3);
        cd = 2'b01; step(1);
        cd = 2'b11; step(2);
        check_output("reopen_after_fall", gnt_seen, 5);
        apply_stimulus(0, 0, 8'h00, 4'h0, 0, 8'h00);
        vde = 1'b1; step(3);

        // Reset lands mid-window after two writes.
        apply_stimulus(1, 1, 8'h55, 4'h7, 0, 8'h00);
        cd = 2'b01; vde = 1'b0; step(1);
        cd = 2'b11; step(2);
        check_output("pre_reset_write", mem_we, 1);
        reset = 1'b0;
        #1;
        check_output("reset_kills_write", mem_we, 0);
        check_output("reset_kills_window", upd_window, 0);
        check_output("reset_kills_gnt", gl_gnt, 0);
        step(2);
        reset = 1'b1;
        clear_counts();
        step(6);
        check_output("no_window_after_reset", gnt_seen, 0);
        check_output("scan_after_reset", upd_window, 0);
        apply_stimulus(0, 0, 8'h00, 4'h0, 0, 8'h00);
        vde = 1'b1; step(2);

        // Pause holds the frame count: 1 + 4 paused + 2 -> tick on frame 7.
        clear_counts();
        speed_div = 5'd3;
        run_frame(2, 3, 3);
        pause = 1'b1;
        repeat (4) run_frame(2, 3, 3);
        pause = 1'b0;
        repeat (2) run_frame(2, 3, 3);
        check_output("pause_frames", fs_seen, 7);
        check_output("pause_tick_frames", tick_mask, 32'h40);

        // Lowering the divider below the count fires on the next fall.
        clear_counts();
        speed_div = 5'd5;
        repeat (2) run_frame(2, 3, 3);
        speed_div = 5'd2;
        run_frame(2, 3, 3);
        check_output("lowered_div_tick", tick_mask, 32'h4);

        // A divider of 0 ticks every frame.
        clear_counts();
        speed_div = 5'd0;
        repeat (2) run_frame(2, 3, 3);
        check_output("div_zero_ticks", tick_mask, 32'h3);

        step(2);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
